// File: rtl/program_loader.sv
// program_loader: receives a length-prefixed byte stream from a host and writes
// the assembled little-endian instruction words into the core instruction memory.
module program_loader #(
  parameter int WORD_LEN  = 32,
  parameter int MAX_WORDS = 1024,
  parameter int TIMEOUT   = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                byte_valid,
  input  logic [7:0]          byte_data,
  output logic                byte_ready,
  input  logic                restart,
  output logic                ins_write,
  output logic [WORD_LEN-1:0] instruction_out,
  output logic [10:0]         words_loaded,
  output logic                core_run,
  output logic                load_err
);
  localparam int NB = WORD_LEN / 8;
  localparam int IW = NB > 1 ? $clog2(NB) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [2:0] HDR0  = 3'd0;
  localparam logic [2:0] HDR1  = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;
  localparam logic [2:0] ERROR = 3'd5;

  logic [2:0]          state_q, state_d;
  logic [15:0]         len_q, len_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [WORD_LEN-1:0] word_q, word_d;
  logic [WORD_LEN-1:0] instr_q, instr_d;
  logic [10:0]         cnt_q, cnt_d;
  logic [TW-1:0]       to_q, to_d;
  logic                wr_q, wr_d;
  logic                acc, last;
  logic [15:0]         hdr_len;
  logic [WORD_LEN-1:0] packed_word;

  assign byte_ready      = state_q == HDR0 || state_q == HDR1 || state_q == DATA;
  assign acc             = byte_valid && byte_ready;
  assign last            = idx_q == IW'(NB - 1);
  assign hdr_len         = {byte_data, len_q[7:0]};
  // Bytes shift in from the top so the first byte lands in bits [7:0].
  assign packed_word     = (word_q >> 8) | (WORD_LEN'(byte_data) << (WORD_LEN - 8));
  assign ins_write       = wr_q;
  assign instruction_out = instr_q;
  assign words_loaded    = cnt_q;
  assign core_run        = state_q == DONE;
  assign load_err        = state_q == ERROR;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    word_d  = word_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    to_d    = (state_q == HDR1 || state_q == DATA) && !acc ? to_q + TW'(1) : '0;
    if (restart) begin
      state_d = HDR0;
      len_d   = '0;
      idx_d   = '0;
      word_d  = '0;
      cnt_d   = '0;
      to_d    = '0;
    end else begin
      case (state_q)
        HDR0: if (acc) begin
          len_d[7:0] = byte_data;
          state_d    = HDR1;
        end
        HDR1: if (acc) begin
          len_d   = hdr_len;
          state_d = (hdr_len == 16'd0 || hdr_len > 16'(MAX_WORDS)) ? ERROR : DATA;
        end else if (to_d == TW'(TIMEOUT)) begin
          state_d = ERROR;
        end
        DATA: if (acc) begin
          word_d  = packed_word;
          idx_d   = last ? '0 : idx_q + IW'(1);
          instr_d = last ? packed_word : instr_q;
          state_d = last ? WRITE : DATA;
        end else if (to_d == TW'(TIMEOUT)) begin
          state_d = ERROR;
        end
        WRITE: begin
          cnt_d   = cnt_q + 11'd1;
          state_d = ({5'd0, cnt_d} == len_q) ? DONE : DATA;
        end
        default: ;
      endcase
    end
    wr_d = state_d == WRITE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= HDR0;
      len_q   <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      instr_q <= '0;
      cnt_q   <= '0;
      to_q    <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      wr_q    <= wr_d;
    end
  end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed and randomized loads checked against a
// byte-stream reference model of the loader protocol.
module tb_program_loader;
  localparam int NB = 4;
  localparam int TO = 1000;
  localparam int MW = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready;
  logic        restart = 1'b0;
  logic        ins_write;
  logic [31:0] instruction_out;
  logic [10:0] words_loaded;
  logic        core_run;
  logic        load_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cnt = 0;
  logic [31:0] wq[$];
  int pc[$];

  program_loader #(.WORD_LEN(32), .MAX_WORDS(MW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .restart(restart), .ins_write(ins_write),
    .instruction_out(instruction_out), .words_loaded(words_loaded),
    .core_run(core_run), .load_err(load_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Mid-cycle view of what the next rising edge will see.
  always @(negedge clk) begin
    if (byte_valid && byte_ready) acc_cnt++;
    if (ins_write) begin
      wq.push_back(instruction_out);
      pc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    byte_valid = 1'b0;
    repeat (gap) step();
    byte_valid = 1'b1;
    byte_data  = b;
    for (int n = 0; !byte_ready; n++) begin
      if (n == 20) begin
        chk("ready_wait", byte_ready, 1);
        byte_valid = 1'b0;
        return;
      end
      step();
    end
    step();
    byte_valid = 1'b0;
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    step();
    restart = 1'b0;
  endtask

  task automatic run_load(input int len, input int maxgap);
    logic [7:0]  bs[$];
    logic [31:0] exp_w;
    int base, abase;
    pulse_restart();
    bs = {};
    bs.push_back(8'(len));
    bs.push_back(8'(len >> 8));
    for (int i = 0; i < len * NB; i++) bs.push_back(8'($urandom));
    base  = wq.size();
    abase = acc_cnt;
    foreach (bs[i]) send(bs[i], $urandom_range(0, maxgap));
    step();
    step();
    chk("load_pulses", 64'(wq.size() - base), 64'(len));
    for (int w = 0; w < len && base + w < wq.size(); w++) begin
      exp_w = 0;
      for (int k = 0; k < NB; k++) exp_w |= 32'(bs[2 + w * NB + k]) << (8 * k);
      chk("load_word", wq[base + w], exp_w);
    end
    chk("load_accepts", 64'(acc_cnt - abase), 64'(len * NB + 2));
    chk("load_count", words_loaded, 64'(len));
    chk("load_run", core_run, 1);
    chk("load_err", load_err, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int base, abase;
    logic [7:0] s28[10];
    s28 = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    #1;
    chk("rst_ready", byte_ready, 1);
    chk("rst_write", ins_write, 0);
    chk("rst_instr", instruction_out, 0);
    chk("rst_words", words_loaded, 0);
    chk("rst_run", core_run, 0);
    chk("rst_err", load_err, 0);
    step();
    step();
    rst = 1'b1;
    step();

    base = wq.size();
    abase = acc_cnt;
    foreach (s28[i]) send(s28[i], 0);
    step();
    byte_valid = 1'b1;
    byte_data  = 8'hAA;
    repeat (3) step();
    byte_valid = 1'b0;
    chk("basic_pulses", 64'(wq.size() - base), 2);
    if (wq.size() - base >= 2) begin
      chk("basic_word0", wq[base], 32'h00500013);
      chk("basic_word1", wq[base + 1], 32'h00100093);
      chk("basic_rate", 64'(pc[base + 1] - pc[base]), 64'(NB + 1));
    end
    chk("basic_words", words_loaded, 2);
    chk("basic_run", core_run, 1);
    chk("basic_accepts", 64'(acc_cnt - abase), 10);
    chk("done_ready", byte_ready, 0);
    chk("done_write", ins_write, 0);
    chk("done_instr", instruction_out, 32'h00100093);

    pulse_restart();
    chk("restart_ready", byte_ready, 1);
    chk("restart_words", words_loaded, 0);
    chk("restart_run", core_run, 0);
    base = wq.size();
    send(8'h00, 0);
    chk("zero_hdr1_err", load_err, 0);
    send(8'h00, 0);
    chk("zero_err", load_err, 1);
    chk("zero_ready", byte_ready, 0);
    repeat (3) step();
    chk("zero_pulses", 64'(wq.size() - base), 0);

    pulse_restart();
    send(8'h00, 0);
    send(8'h04, 0);
    chk("max_ok_err", load_err, 0);
    chk("max_ok_ready", byte_ready, 1);
    pulse_restart();
    send(8'h01, 0);
    send(8'h04, 0);
    chk("over_err", load_err, 1);
    chk("over_run", core_run, 0);
    pulse_restart();
    chk("over_restart_ready", byte_ready, 1);
    chk("over_restart_err", load_err, 0);

    pulse_restart();
    base = wq.size();
    send(8'h01, 0);
    send(8'h00, 0);
    for (int i = 0; i < 3; i++) send(8'($urandom), 0);
    repeat (TO - 1) step();
    chk("timeout_early", load_err, 0);
    step();
    chk("timeout_err", load_err, 1);
    chk("timeout_pulses", 64'(wq.size() - base), 0);

    pulse_restart();
    send(8'h01, 0);
    repeat (TO - 1) step();
    chk("hdr1_timeout_early", load_err, 0);
    step();
    chk("hdr1_timeout_err", load_err, 1);

    pulse_restart();
    repeat (TO + 5) step();
    chk("hdr0_no_timeout", load_err, 0);
    chk("hdr0_ready", byte_ready, 1);

    pulse_restart();
    base = wq.size();
    send(8'h03, 0);
    send(8'h00, 0);
    for (int i = 0; i < 2 * NB; i++) send(8'($urandom), 0);
    chk("rs_write_cycle", ins_write, 1);
    restart = 1'b1;
    step();
    restart = 1'b0;
    chk("rs_pulses", 64'(wq.size() - base), 2);
    chk("rs_words", words_loaded, 0);
    chk("rs_ready", byte_ready, 1);
    chk("rs_write_gone", ins_write, 0);
    run_load(3, 0);

    for (int t = 0; t < 6; t++) run_load($urandom_range(1, 6), 3);
    run_load(40, 0);

    pulse_restart();
    send(8'h01, 0);
    send(8'h00, 0);
    send(8'h5A, 0);
    send(8'hC3, 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_ready", byte_ready, 1);
    chk("arst_write", ins_write, 0);
    chk("arst_instr", instruction_out, 0);
    chk("arst_words", words_loaded, 0);
    chk("arst_run", core_run, 0);
    chk("arst_err", load_err, 0);
    step();
    rst = 1'b1;
    step();
    run_load(2, 2);

    pulse_restart();
    send(8'h02, 0);
    send(8'h00, 0);
    for (int i = 0; i < NB; i++) send(8'($urandom), 0);
    chk("wr_rst_pre", ins_write, 1);
    #2 rst = 1'b0;
    #1;
    chk("wr_rst_write", ins_write, 0);
    chk("wr_rst_words", words_loaded, 0);
    step();
    rst = 1'b1;
    step();
    run_load(1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
